platform_manager: RTL
=====================

// Module: platform_manager
// PURPOSE
//  Holds and updates the platform field for the gameplay screen.
//  - Builds a fresh field when the menu-to-game transition pulses loadplat.
//  - On each frame tick in the Game state, scrolls every platform down by scroll_amt.
//  - Respawns any platform that falls off the bottom at the top, with a new random X.
//  - Drives refresh_en back to the game state machine while a field walk is running.
//  - Exposes platform coordinates to the sprite/colour mapper through an index read port.
// PARAMETERS
//  NUM_PLAT   8         number of platforms (2..16)
//  SPACING    60        initial vertical gap in px; NUM_PLAT*SPACING <= SCREEN_H
//  X_OFFSET   32        px added to the 9-bit random X
//  LFSR_SEED  16'hACE1  LFSR reset/reload value; must be nonzero
// PORTS
//  Clock       in   1   system clock
//  Reset       in   1   asynchronous, active-high reset
//  outstate    in   3   game state code: 000 menu, 001 game, 010 pause, 011 refreshing
//  loadplat    in   1   one-cycle request to rebuild the field
//  frame_tick  in   1   one-cycle strobe per video frame, synchronous to Clock
//  scroll_amt  in   10  px to shift platforms down this frame (0..SCREEN_H-1)
//  rd_idx      in   4   platform index for the read port
//  plat_x      out  10  X of platform rd_idx (combinational read)
//  plat_y      out  10  Y of platform rd_idx (combinational read)
//  refresh_en  out  1   high while INIT or SCROLL is active
//  height      out  16  total px scrolled since the last loadplat, saturating
// BEHAVIOUR
//  Reset: state IDLE, all plat_x/plat_y 0, refresh_en 0, height 0, lfsr LFSR_SEED, index 0.
//  FSM states: IDLE, INIT, SCROLL. Walks process one platform per cycle, idx 0..NUM_PLAT-1.
//  IDLE -> INIT: on loadplat, from any state. loadplat has highest priority.
//   - On entry: idx=0, y_acc=0, lfsr=LFSR_SEED, height=0.
//  INIT, per cycle:
//   - y[idx] = y_acc; x[idx] = lfsr[8:0] + X_OFFSET; then lfsr advances and y_acc += SPACING.
//   - Returns to IDLE after idx = NUM_PLAT-1. Lasts exactly NUM_PLAT cycles.
//  IDLE -> SCROLL: on frame_tick while outstate==001 and no loadplat.
//   - scroll_amt is latched into amt_q at this point; idx=0.
//   - height += amt_q, saturating at 16'hFFFF.
//   - frame_tick in any other outstate, or while a walk is active, is dropped.
//  SCROLL, per cycle:
//   - sum = {1'b0,y[idx]} + amt_q, computed 11 bits wide.
//   - If sum >= SCREEN_H: y = sum - SCREEN_H, x = lfsr[8:0] + X_OFFSET, lfsr advances.
//   - Otherwise: y = sum[9:0]; x and lfsr are unchanged.
//   - Returns to IDLE after NUM_PLAT cycles. amt_q=0 still walks (refresh_en pulses).
//  refresh_en: registered. Asserts the cycle after entry and deasserts the cycle after the last index.
//  LFSR: 16-bit Galois, taps 16,14,13,11. Advances only when an X is generated.
//  Read port: rd_idx >= NUM_PLAT returns x=0, y=0.
//   - Reading the index written this cycle returns the old value until the next edge.
//  Reset mid-walk: aborts immediately to reset values.
//  loadplat mid-SCROLL: abandons the scroll and restarts INIT next cycle.
// CONFIGURATION
//  PLAT_MOVING_EN defined:
//   - During SCROLL, odd-index platforms also move 2 px horizontally, in a per-platform direction.
//   - Each direction bit resets to 0 (right).
//   - Direction flips when x would exceed SCREEN_W-PLAT_W or drop below 0; x is clamped in that cycle.
//   - A respawned platform keeps its direction bit.
//  PLAT_MOVING_EN undefined: X changes only on INIT and respawn; no direction registers are built.
// STRUCTURE
//  doodle_pkg: SCREEN_W=640, SCREEN_H=480, PLAT_W=64, outstate codes (GS_MENU/GS_GAME/GS_PAUSE/GS_REFRESH),
//   typedef plat_t {logic [9:0] x, y;}.
//  Sub-module plat_lfsr: 16-bit Galois LFSR with load and advance inputs.
// TESTING (NUM_PLAT=8, SPACING=60)
//  1. Reset -> refresh_en=0, height=0, every rd_idx reads x=0, y=0.
//  2. loadplat pulse -> refresh_en high 8 cycles; y[0..7]=0,60,...,420; x = LFSR sequence + 32.
//  3. outstate=001, frame_tick, scroll_amt=5 -> y=5..425, x unchanged, height=5.
//  4. scroll_amt=70 after test 3 -> y[7]=495-480=15 with new x; others +70; height=75.
//  5. frame_tick with outstate=010 or 000 -> no walk, refresh_en stays 0, positions unchanged.
//  6. loadplat at SCROLL idx 3 -> INIT restarts, field = test 2 values; Reset mid-INIT -> all 0.

Source files
------------

// File: rtl/doodle_pkg.sv
// rtl/doodle_pkg.sv - shared screen geometry, game-state codes and platform types
package doodle_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PLAT_W   = 64;

  localparam logic [2:0] GS_MENU    = 3'b000;
  localparam logic [2:0] GS_GAME    = 3'b001;
  localparam logic [2:0] GS_PAUSE   = 3'b010;
  localparam logic [2:0] GS_REFRESH = 3'b011;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } plat_t;

  typedef enum logic [1:0] {
    PM_IDLE,
    PM_INIT,
    PM_SCROLL
  } pm_state_t;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

endpackage

// File: rtl/plat_lfsr.sv
// rtl/plat_lfsr.sv - 16-bit Galois LFSR with reload and advance, exposes 9 random bits
module plat_lfsr
  import doodle_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       load,
  input  logic       advance,
  output logic [8:0] rand9
);

  logic [15:0] state_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= SEED;
    end else if (load) begin
      state_q <= SEED;
    end else if (advance) begin
      state_q <= lfsr_step(state_q);
    end
  end

  assign rand9 = state_q[8:0];

endmodule

// File: rtl/platform_manager.sv
// rtl/platform_manager.sv - builds, scrolls and respawns the gameplay platform field
// Optional horizontal motion of odd platforms: define PLAT_MOVING_EN.
module platform_manager
  import doodle_pkg::*;
#(
  parameter int          NUM_PLAT  = 8,
  parameter int          SPACING   = 60,
  parameter int          X_OFFSET  = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [2:0]  outstate,
  input  logic        loadplat,
  input  logic        frame_tick,
  input  logic [9:0]  scroll_amt,
  input  logic [3:0]  rd_idx,
  output logic [9:0]  plat_x,
  output logic [9:0]  plat_y,
  output logic        refresh_en,
  output logic [15:0] height
);

  pm_state_t   state;
  logic [3:0]  idx;
  logic [9:0]  y_acc;
  logic [9:0]  amt_q;
  plat_t       plats [NUM_PLAT];

  logic [8:0]  rand9;
  logic [9:0]  new_x;
  plat_t       cur;
  logic [10:0] sum;
  logic        wrap;
  logic        last;
  logic        start_scroll;
  logic [16:0] h_sum;
  logic [15:0] h_next;
  logic [9:0]  keep_x;
  logic        lfsr_adv;

  assign new_x        = 10'(rand9) + 10'(X_OFFSET);
  assign sum          = {1'b0, cur.y} + {1'b0, amt_q};
  assign wrap         = (sum >= 11'(SCREEN_H));
  assign last         = (idx == 4'(NUM_PLAT - 1));
  assign start_scroll = (frame_tick && (outstate == GS_GAME));
  assign h_sum        = {1'b0, height} + {7'b0, scroll_amt};
  assign h_next       = h_sum[16] ? 16'hFFFF : h_sum[15:0];
  assign lfsr_adv     = (state == PM_INIT) || ((state == PM_SCROLL) && wrap);

  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_PLAT; i++) begin
      if (idx == 4'(i)) cur = plats[i];
    end
  end

  // Writes land on the next edge, so a same-cycle read sees the old entry
  always_comb begin
    plat_x = '0;
    plat_y = '0;
    for (int i = 0; i < NUM_PLAT; i++) begin
      if (rd_idx == 4'(i)) begin
        plat_x = plats[i].x;
        plat_y = plats[i].y;
      end
    end
  end

  plat_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .Clock  (Clock),
    .Reset  (Reset),
    .load   (loadplat),
    .advance(lfsr_adv),
    .rand9  (rand9)
  );

`ifdef PLAT_MOVING_EN
  logic [NUM_PLAT-1:0] dir;
  logic                dir_cur;
  logic                dir_new;
  logic [9:0]          mv_x;

  always_comb begin
    dir_cur = 1'b0;
    for (int i = 0; i < NUM_PLAT; i++) begin
      if (idx == 4'(i)) dir_cur = dir[i];
    end
  end

  // Odd platforms drift 2 px, bouncing off the right edge and column 0
  always_comb begin
    mv_x    = cur.x;
    dir_new = dir_cur;
    if (idx[0]) begin
      if (!dir_cur) begin
        if (({1'b0, cur.x} + 11'd2) > 11'(SCREEN_W - PLAT_W)) begin
          mv_x    = 10'(SCREEN_W - PLAT_W);
          dir_new = 1'b1;
        end else begin
          mv_x = cur.x + 10'd2;
        end
      end else begin
        if (cur.x < 10'd2) begin
          mv_x    = 10'd0;
          dir_new = 1'b0;
        end else begin
          mv_x = cur.x - 10'd2;
        end
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      dir <= '0;
    end else if (!loadplat && (state == PM_SCROLL) && !wrap) begin
      for (int i = 0; i < NUM_PLAT; i++) begin
        if (idx == 4'(i)) dir[i] <= dir_new;
      end
    end
  end

  assign keep_x = mv_x;
`else
  assign keep_x = cur.x;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= PM_IDLE;
      idx        <= '0;
      y_acc      <= '0;
      amt_q      <= '0;
      height     <= '0;
      refresh_en <= 1'b0;
      for (int i = 0; i < NUM_PLAT; i++) plats[i] <= '0;
    end else if (loadplat) begin
      state      <= PM_INIT;
      idx        <= '0;
      y_acc      <= '0;
      height     <= '0;
      refresh_en <= 1'b1;
    end else begin
      case (state)
        PM_IDLE: begin
          if (start_scroll) begin
            state      <= PM_SCROLL;
            idx        <= '0;
            amt_q      <= scroll_amt;
            height     <= h_next;
            refresh_en <= 1'b1;
          end
        end
        PM_INIT: begin
          for (int i = 0; i < NUM_PLAT; i++) begin
            if (idx == 4'(i)) plats[i] <= '{x: new_x, y: y_acc};
          end
          y_acc <= y_acc + 10'(SPACING);
          idx   <= idx + 4'd1;
          if (last) begin
            state      <= PM_IDLE;
            idx        <= '0;
            refresh_en <= 1'b0;
          end
        end
        PM_SCROLL: begin
          for (int i = 0; i < NUM_PLAT; i++) begin
            if (idx == 4'(i)) begin
              if (wrap) plats[i] <= '{x: new_x, y: 10'(sum - 11'(SCREEN_H))};
              else      plats[i] <= '{x: keep_x, y: sum[9:0]};
            end
          end
          idx <= idx + 4'd1;
          if (last) begin
            state      <= PM_IDLE;
            idx        <= '0;
            refresh_en <= 1'b0;
          end
        end
        default: begin
          state      <= PM_IDLE;
          refresh_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
